// File: rtl/canny_pkg.sv
// Shared defaults, widths and state encoding for the Canny line-buffer controller.
package canny_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_WIDTH  = 1920;
  localparam int IMG_HEIGHT = 1080;
  localparam int COL_W      = $clog2(IMG_WIDTH);
  localparam int ROW_W      = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    SYNC = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_ram.sv
// Line-delay FIFO: circular buffer with free-running, non-resettable pointers.
// Registered read returns the pre-write value on a same-address collision, 0 when idle.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1920,
  localparam int PTR_W     = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
      wr_ptr_reg      <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (rd_en) begin
      rd_data    <= mem[rd_ptr_reg];
      rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/canny_line_buf_ctrl.sv
// Sequences two line-delay FIFOs into an aligned (top, mid, bot) column stream.
// Optional CANNY_LBC_ERR_CHK_EN adds a sticky protocol-error flag (err_sticky).
module canny_line_buf_ctrl #(
  parameter int DATA_WIDTH = canny_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = canny_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = canny_pkg::IMG_HEIGHT,
  localparam int COL_BITS  = $clog2(IMG_WIDTH),
  localparam int ROW_BITS  = $clog2(IMG_HEIGHT)
) (
`ifdef CANNY_LBC_ERR_CHK_EN
  output logic                  err_sticky,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  fifo0_wr_en,
  output logic [DATA_WIDTH-1:0] fifo0_wr_data,
  output logic                  fifo0_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo0_rd_data,
  output logic                  fifo1_wr_en,
  output logic [DATA_WIDTH-1:0] fifo1_wr_data,
  output logic                  fifo1_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo1_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_top,
  output logic [DATA_WIDTH-1:0] out_mid,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic [COL_BITS-1:0]   out_col,
  output logic [ROW_BITS-1:0]   out_row,
  output logic                  out_eof
);

  import canny_pkg::*;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [ROW_BITS-1:0] ROW_TWO  = ROW_BITS'(2);

  state_t              state_reg, state_next;
  logic [COL_BITS-1:0] col_reg, col_next, cur_col;
  logic [ROW_BITS-1:0] row_reg, row_next, cur_row;
  logic                restart, pix_accept, dummy, accept, last_col, eof_now;

  logic                accept_d1_reg, dummy_d1_reg, eof_d1_reg;
  logic [COL_BITS-1:0] col_d1_reg;
  logic [ROW_BITS-1:0] row_d1_reg;
  logic [DATA_WIDTH-1:0] bot_d1_reg;

  always_comb begin
    restart    = frame_start && (state_reg == IDLE || state_reg == DONE ||
                                 (state_reg == RUN && col_reg == '0));
    cur_col    = restart ? '0 : col_reg;
    cur_row    = restart ? '0 : row_reg;
    pix_accept = in_valid && (restart || (state_reg == RUN && !frame_start));
    // Each SYNC cycle is a zero-data accept that pads the FIFOs out to the line end.
    dummy      = (state_reg == SYNC);
    accept     = pix_accept || dummy;
    last_col   = (cur_col == COL_LAST);
    eof_now    = pix_accept && last_col && (cur_row == ROW_LAST);

    state_next = state_reg;
    col_next   = cur_col;
    row_next   = cur_row;
    if (restart) begin
      state_next = RUN;
    end else if (state_reg == RUN && frame_start) begin
      state_next = SYNC;
    end
    if (accept) begin
      if (!last_col) begin
        col_next = cur_col + 1'b1;
      end else begin
        col_next = '0;
        if (dummy || cur_row == ROW_LAST) begin
          row_next   = '0;
          state_next = dummy ? RUN : DONE;
        end else begin
          row_next = cur_row + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy          = dummy;
    fifo0_wr_en   = accept;
    fifo0_wr_data = pix_accept ? in_data : '0;
    fifo0_rd_en   = accept && (cur_row != '0);
    fifo1_rd_en   = accept && (cur_row >= ROW_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_reg       <= '0;
      row_reg       <= '0;
      accept_d1_reg <= 1'b0;
      dummy_d1_reg  <= 1'b0;
      eof_d1_reg    <= 1'b0;
      col_d1_reg    <= '0;
      row_d1_reg    <= '0;
      bot_d1_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      accept_d1_reg <= accept;
      dummy_d1_reg  <= dummy;
      eof_d1_reg    <= eof_now;
      col_d1_reg    <= cur_col;
      row_d1_reg    <= cur_row;
      bot_d1_reg    <= fifo0_wr_data;
    end
  end

  // FIFO 1 is fed only by forwarding what FIFO 0 returned one cycle earlier.
  assign fifo1_wr_en   = accept_d1_reg && (row_d1_reg != '0);
  assign fifo1_wr_data = fifo0_rd_data;

  assign out_valid = accept_d1_reg && !dummy_d1_reg && (row_d1_reg >= ROW_TWO);
  assign out_top   = out_valid ? fifo1_rd_data : '0;
  assign out_mid   = out_valid ? fifo0_rd_data : '0;
  assign out_bot   = out_valid ? bot_d1_reg : '0;
  assign out_col   = out_valid ? col_d1_reg : '0;
  assign out_row   = out_valid ? row_d1_reg : '0;
  assign out_eof   = out_valid && eof_d1_reg;

`ifdef CANNY_LBC_ERR_CHK_EN
  logic err_event;
  assign err_event = (in_valid && dummy) ||
                     (in_valid && !frame_start && (state_reg == IDLE || state_reg == DONE)) ||
                     (frame_start && dummy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_event) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_canny_line_buf_ctrl.sv
// Bench for canny_line_buf_ctrl on an 8x4 image with two fifo_ram line buffers.
// Expected columns are derived from the driven image and checked by a cycle-stamped scoreboard.
module tb_canny_line_buf_ctrl;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en;
  logic [DW-1:0] fifo0_wr_data, fifo0_rd_data, fifo1_wr_data, fifo1_rd_data;
  logic          out_valid, out_eof;
  logic [DW-1:0] out_top, out_mid, out_bot;
  logic [2:0]    out_col;
  logic [1:0]    out_row;
`ifdef CANNY_LBC_ERR_CHK_EN
  logic          err_sticky;
`endif

  always #5 clk = ~clk;

  canny_line_buf_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
`ifdef CANNY_LBC_ERR_CHK_EN
    .err_sticky(err_sticky),
`endif
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy),
    .fifo0_wr_en(fifo0_wr_en), .fifo0_wr_data(fifo0_wr_data),
    .fifo0_rd_en(fifo0_rd_en), .fifo0_rd_data(fifo0_rd_data),
    .fifo1_wr_en(fifo1_wr_en), .fifo1_wr_data(fifo1_wr_data),
    .fifo1_rd_en(fifo1_rd_en), .fifo1_rd_data(fifo1_rd_data),
    .out_valid(out_valid), .out_top(out_top), .out_mid(out_mid), .out_bot(out_bot),
    .out_col(out_col), .out_row(out_row), .out_eof(out_eof)
  );

  fifo_ram #(.DATA_WIDTH(DW), .DATA_DEPTH(W)) fifo0 (
    .clk(clk), .wr_en(fifo0_wr_en), .wr_data(fifo0_wr_data),
    .rd_en(fifo0_rd_en), .rd_data(fifo0_rd_data)
  );

  fifo_ram #(.DATA_WIDTH(DW), .DATA_DEPTH(W)) fifo1 (
    .clk(clk), .wr_en(fifo1_wr_en), .wr_data(fifo1_wr_data),
    .rd_en(fifo1_rd_en), .rd_data(fifo1_rd_data)
  );

  typedef struct {
    logic [DW-1:0] top;
    logic [DW-1:0] mid;
    logic [DW-1:0] bot;
    int            col;
    int            row;
    logic          eof;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] img [H][W];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every valid column must match the scoreboard head in content and timing.
  always @(negedge clk) begin
    if (out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got out_valid=1 row=%0d col=%0d, required no output", out_row, out_col);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_top !== mon_e.top || out_mid !== mon_e.mid || out_bot !== mon_e.bot ||
            out_col !== 3'(mon_e.col) || out_row !== 2'(mon_e.row) ||
            out_eof !== mon_e.eof || cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL column: got top=%h mid=%h bot=%h col=%0d row=%0d eof=%b cyc=%0d, required top=%h mid=%h bot=%h col=%0d row=%0d eof=%b cyc=%0d",
                   out_top, out_mid, out_bot, out_col, out_row, out_eof, cyc,
                   mon_e.top, mon_e.mid, mon_e.bot, mon_e.col, mon_e.row, mon_e.eof, mon_e.cyc);
        end else begin
          $display("[TB] out row=%0d col=%0d top=%h mid=%h bot=%h eof=%b",
                   out_row, out_col, out_top, out_mid, out_bot, out_eof);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      tests++;
      fails++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_out: got out_valid=0 at cyc %0d, required column row=%0d col=%0d",
               cyc, mon_e.row, mon_e.col);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [DW-1:0] v, input logic start, input int r, input int c);
    exp_t e;
    img[r][c] = v;
    if (r >= 2) begin
      e.top = img[r-2][c];
      e.mid = img[r-1][c];
      e.bot = v;
      e.col = c;
      e.row = r;
      e.eof = (r == H-1) && (c == W-1);
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    frame_start = start;
    in_valid    = 1'b1;
    in_data     = v;
    tick();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
  endtask

  task automatic send_pixels(input logic [DW-1:0] base, input bit gap, input bit start, input int count);
    for (int i = 0; i < count; i++) begin
      int r = i / W;
      int c = i % W;
      drive_pix(base + DW'(r*16 + c), start && (i == 0), r, c);
      if (gap) tick();
    end
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    tests++;
    if ({busy, out_valid, fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en, out_eof,
         out_top, out_mid, out_bot, out_col, out_row, fifo0_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b ov=%b en=%b%b%b%b, required all zero",
               busy, out_valid, fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en);
    end
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    tests++;
    if ({fifo0_wr_en, fifo0_rd_en, fifo1_rd_en, busy} !== 4'b0) begin
      fails++;
      $display("FAIL idle_ignore: got wr0=%b rd0=%b rd1=%b busy=%b, required 0", fifo0_wr_en, fifo0_rd_en, fifo1_rd_en, busy);
    end
    tick();
    in_valid = 1'b0; in_data = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    send_pixels(8'h00, 1'b0, 1'b1, W*H);
    drain();
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    tests++;
    if ({fifo0_wr_en, fifo0_rd_en, fifo1_rd_en} !== 3'b0) begin
      fails++;
      $display("FAIL done_ignore: got wr0=%b rd0=%b rd1=%b, required 0", fifo0_wr_en, fifo0_rd_en, fifo1_rd_en);
    end
    tick();
    in_valid = 1'b0; in_data = '0;
    drain();
  endtask

  task automatic test_gapped();
    send_pixels(8'h00, 1'b1, 1'b1, W*H);
    drain();
  endtask

  task automatic test_abort_mid_line();
    int busy_cnt = 0;
    int dummy_cnt = 0;
    send_pixels(8'h00, 1'b0, 1'b1, 2*W + 5);
    frame_start = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || fifo0_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_start_cycle: got busy=%b wr0=%b, required 0 0", busy, fifo0_wr_en);
    end
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!busy) break;
      busy_cnt++;
      // Stray pixels and a second frame_start during realignment must be ignored.
      in_valid = 1'b1; in_data = 8'hAA; frame_start = (k == 0);
      #1;
      if (fifo0_wr_en && fifo0_wr_data == 8'h00 && fifo0_rd_en && fifo1_rd_en) dummy_cnt++;
      tick();
      in_valid = 1'b0; in_data = '0; frame_start = 1'b0;
    end
    tests++;
    if (busy_cnt != 3) begin
      fails++;
      $display("FAIL abort_busy_cycles: got %0d, required 3", busy_cnt);
    end
    tests++;
    if (dummy_cnt != 3) begin
      fails++;
      $display("FAIL abort_dummy_accepts: got %0d, required 3", dummy_cnt);
    end
    send_pixels(8'h00, 1'b0, 1'b0, W*H);
    drain();
  endtask

  task automatic test_restart_col0();
    int busy_seen = 0;
    send_pixels(8'h40, 1'b0, 1'b1, 2*W);
    frame_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (busy) busy_seen++;
      tick();
      frame_start = 1'b0;
    end
    tests++;
    if (busy_seen != 0) begin
      fails++;
      $display("FAIL restart_col0_busy: got %0d busy cycles, required 0", busy_seen);
    end
    send_pixels(8'h00, 1'b0, 1'b0, W*H);
    drain();
  endtask

  task automatic test_two_frames();
    send_pixels(8'h80, 1'b0, 1'b1, W*H);
    send_pixels(8'h00, 1'b0, 1'b1, W*H);
    drain();
  endtask

`ifdef CANNY_LBC_ERR_CHK_EN
  task automatic test_err_sticky();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL err_after_rst: got %b, required 0", err_sticky);
    end
    in_valid = 1'b1; in_data = 8'h11;
    #1;
    tests++;
    if ({fifo0_wr_en, fifo0_rd_en, fifo1_rd_en} !== 3'b0) begin
      fails++;
      $display("FAIL err_idle_enables: got wr0=%b rd0=%b rd1=%b, required 0", fifo0_wr_en, fifo0_rd_en, fifo1_rd_en);
    end
    tick();
    in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    tests++;
    if (err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %b, required 1", err_sticky);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b, required 0", err_sticky);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_abort_mid_line();
    test_restart_col0();
    test_two_frames();
`ifdef CANNY_LBC_ERR_CHK_EN
    test_err_sticky();
`endif
    drain();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending columns, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/canny_line_buf_ctrl.md
Name: canny_line_buf_ctrl

Overview:
Sequencer for the two 8-bit, IMG_WIDTH-deep line-delay FIFOs in the Canny front-end. It turns a raster pixel stream into a vertically aligned 3-row column (top, mid, bottom) for the 3x3 window stage that follows. It drives the write and read enables of both FIFOs and tracks row and column position. It keeps the pointers of the non-resettable FIFOs line-aligned, including when a frame is aborted mid-line.

Parameters:
DATA_WIDTH, 8, pixel width.
IMG_WIDTH, 1920, pixels per line; equals FIFO depth.
IMG_HEIGHT, 1080, lines per frame.

Ports:
clk  in  1  pixel clock.
rst  in  1  reset, asynchronous, active-high.
frame_start  in  1  one-cycle pulse marking the start of a frame.
in_valid  in  1  pixel strobe.
in_data  in  DATA_WIDTH  pixel value.
busy  out  1  high while realigning; upstream must hold in_valid low.
fifo0_wr_en  out  1  line FIFO 0 write enable.
fifo0_wr_data  out  DATA_WIDTH  line FIFO 0 write data.
fifo0_rd_en  out  1  line FIFO 0 read enable.
fifo0_rd_data  in  DATA_WIDTH  line FIFO 0 read data (registered, 1-cycle latency, 0 when not read).
fifo1_wr_en  out  1  line FIFO 1 write enable.
fifo1_wr_data  out  DATA_WIDTH  line FIFO 1 write data.
fifo1_rd_en  out  1  line FIFO 1 read enable.
fifo1_rd_data  in  DATA_WIDTH  line FIFO 1 read data.
out_valid  out  1  aligned column valid.
out_top / out_mid / out_bot  out  DATA_WIDTH each  rows r-2, r-1, r.
out_col  out  clog2(IMG_WIDTH)  column of the output.
out_row  out  clog2(IMG_HEIGHT)  row r of out_bot.
out_eof  out  1  last column of the last row.

Behaviour:
- Reset state: IDLE. col=0, row=0. All outputs 0; busy=0.
- States: IDLE, RUN, DONE, SYNC.
  - IDLE/DONE + frame_start: go to RUN with col=row=0. If in_valid is high in the same cycle, that pixel is (0,0).
  - In IDLE and DONE, in_valid is ignored and no FIFO enables are driven.
- Pixel accept (RUN and in_valid), combinational enables in the same cycle:
  - fifo0_wr_en=1, fifo0_wr_data=in_data.
  - fifo0_rd_en=(row>=1).
  - fifo1_rd_en=(row>=2).
- Registered one cycle later:
  - fifo1_wr_en = accept_d1 && row_d1>=1, with fifo1_wr_data = fifo0_rd_data.
  - This forwarding is the only path into FIFO 1.
- Column/row counting: col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0, incrementing row. Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) moves the state to DONE.
- Output, latency 1 cycle after accept:
  - out_valid = accept_d1 && row_d1>=2.
  - out_bot = in_data_d1, out_mid = fifo0_rd_data, out_top = fifo1_rd_data.
  - out_col, out_row = registered col/row.
  - out_eof on the final pixel.
  - Rows 0-1 give no output; no border padding.
- frame_start while in RUN:
  - col==0: restart cleanly at (0,0) and go to RUN.
  - col!=0: go to SYNC with busy=1 and in_valid ignored. Emit IMG_WIDTH-col dummy accepts (data 0) using the current row's enable pattern, including the delayed fifo1 write; out_valid stays 0. Then go to RUN at (0,0) and drop busy.
  - frame_start during SYNC is ignored.
- fifo_ram pointers are not reset. rst is legal only at power-up or while col==0; otherwise alignment is undefined.
- Wrap boundary: FIFO pointers wrap in step with col because depth == IMG_WIDTH.

Optional Feature:
CANNY_LBC_ERR_CHK_EN
- Defined: adds output err_sticky (1 bit), cleared by rst. It sets on any of:
  - in_valid while busy;
  - in_valid in IDLE/DONE without frame_start;
  - frame_start in SYNC.
- Undefined: port absent, no extra logic; these events are silently ignored as specified above.

Decomposition:
- Shared package canny_pkg holds:
  - DATA_WIDTH, IMG_WIDTH, IMG_HEIGHT defaults;
  - the state enum (IDLE, RUN, DONE, SYNC);
  - COL_W = clog2(IMG_WIDTH), ROW_W = clog2(IMG_HEIGHT).
- No sub-module. The bench instantiates two fifo_ram with DATA_DEPTH=IMG_WIDTH around the controller.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4.
1. rst, frame_start, then 32 pixels with value = row*16+col, back-to-back -> out_valid only for rows 2-3. Row 2 col 3 gives top=0x03, mid=0x13, bot=0x23; out_eof on (7,3); state DONE.
2. Same frame with in_valid gapped on alternate cycles -> identical output sequence; out_valid 1 cycle after each row≥2 accept.
3. frame_start at row 2 col 5 -> busy for exactly 3 cycles with 3 dummy accepts and out_valid=0. The next full frame is correct, with (2,0) giving top=0x00, mid=0x10, bot=0x20.
4. frame_start at col 0 mid-frame -> no busy; clean restart; counters 0.
5. Two consecutive frames -> second frame outputs match scenario 1 exactly; no stale-data leakage into row 2.
6. With CANNY_LBC_ERR_CHK_EN defined, in_valid in IDLE -> err_sticky=1 and it stays set until rst; no FIFO enable pulses.
